// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle control sequencer: state encoding,
// opcode constants, register-file write selects, ALU codes and the control word.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_IRL,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_BR,
      S_HALT,
      S_ERR
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'h8;
   localparam logic [3:0] OP_STORE = 4'h9;
   localparam logic [3:0] OP_BR    = 4'hA;
   localparam logic [3:0] OP_LOADI = 4'hB;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [2:0] RDW_ALU = 3'd0;
   localparam logic [2:0] RDW_MEM = 3'd1;
   localparam logic [2:0] RDW_IMM = 3'd2;

   localparam logic [2:0] ALU_ADD = 3'd0;

   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic       pc_source;
      logic       mem_rd;
      logic       mem_wr;
      logic       mem_addr_sel;
      logic       alu_src_a;
      logic       alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] imm_shift;
      logic       reg_write;
      logic [2:0] rdw_sel;
      logic       halted;
      logic       error;
   } ctrl_t;

   localparam ctrl_t CTL_RESET = '{mem_rd: 1'b1, default: '0};

   // Opcodes 0x0-0x7 are register-register ALU operations.
   function automatic logic is_alu_op(input logic [3:0] opc);
      return ~opc[3];
   endfunction

endpackage

// File: rtl/mc_control_sequencer_if.sv
// Datapath-facing bundle of the control sequencer: status inputs, control word
// outputs and a debug view of the FSM state.
interface mc_control_sequencer_if #(
   parameter int OP_W  = 4,
   parameter int CMP_W = 2
);
   import cpu_ctrl_pkg::*;

   logic [OP_W-1:0]  op;
   logic [CMP_W-1:0] cmpRst;
   logic             mem_ready;
   logic             IRWrite;
   logic             PCWriteEnable;
   logic             PCSource;
   logic             memEnableRead;
   logic             memEnableWrite;
   logic             memAddrSel;
   logic             ALUSrcA;
   logic             ALUSrcB;
   logic [2:0]       ALUOp;
   logic [1:0]       immShift;
   logic             writeEnable;
   logic [2:0]       regDataWrite;
   logic             halted;
   logic             error;
   state_t           dbg_state;

   // Memory handshake: memEnableRead/memEnableWrite are requests that stay asserted
   // and stable until a cycle with mem_ready=1, which completes the access on that
   // CLK edge; mem_ready is ignored whenever no request is outstanding.
   modport master (
      input  op, cmpRst, mem_ready,
      output IRWrite, PCWriteEnable, PCSource, memEnableRead, memEnableWrite,
             memAddrSel, ALUSrcA, ALUSrcB, ALUOp, immShift, writeEnable,
             regDataWrite, halted, error, dbg_state
   );

   modport slave (
      output op, cmpRst, mem_ready,
      input  IRWrite, PCWriteEnable, PCSource, memEnableRead, memEnableWrite,
             memAddrSel, ALUSrcA, ALUSrcB, ALUOp, immShift, writeEnable,
             regDataWrite, halted, error, dbg_state
   );

endinterface

// File: rtl/mc_wait_timer.sv
// Wait-cycle counter for memory accesses; expired flags the last tolerated
// not-ready cycle so the caller can branch to ERR on that edge.
module mc_wait_timer #(
   parameter int TO_W     = 4,
   parameter int MAX_WAIT = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

   logic [TO_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)   r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en)  r_cnt <= r_cnt + 1'b1;
   end

   // A zero limit disables the timeout entirely.
   assign o_expired = (MAX_WAIT > 0) && i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/mc_control_sequencer.sv
// Multicycle control sequencer: FETCH/IRL/DECODE/EXEC/MEM/WB with bounded memory
// waits; the control word is registered from the next state and opcode.
module mc_control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int OP_W         = 4,
   parameter int CMP_W        = 2,
   parameter int MEM_WAIT_MAX = 15,
   parameter int TO_W         = 4
) (
   input  logic                  CLK,
   input  logic                  reset,
   mc_control_sequencer_if.master bus
);

   state_t     r_state, w_next;
   logic [3:0] r_opc, w_opc;
   ctrl_t      r_ctl, w_ctl;
   logic       w_wait, w_clr, w_en, w_expired;

   // The opcode is captured in DECODE so later phases do not depend on the IR.
   assign w_opc  = (r_state == S_DECODE) ? bus.op[OP_W-1 -: 4] : r_opc;
   assign w_wait = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_en   = w_wait && !bus.mem_ready;
   assign w_clr  = !w_wait || (w_next != r_state);

   mc_wait_timer #(.TO_W(TO_W), .MAX_WAIT(MEM_WAIT_MAX)) u_wait_timer (
      .i_clk     (CLK),
      .i_rst_n   (reset),
      .i_clr     (w_clr),
      .i_en      (w_en),
      .o_expired (w_expired)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (bus.mem_ready) w_next = S_IRL;
                   else if (w_expired) w_next = S_ERR;
         S_IRL:    w_next = S_DECODE;
         S_DECODE: begin
            if (is_alu_op(w_opc)) w_next = S_EXEC;
            else begin
               case (w_opc)
                  OP_LOAD, OP_STORE: w_next = S_EXEC;
                  OP_BR:             w_next = S_BR;
                  OP_LOADI:          w_next = S_WB;
                  OP_HALT:           w_next = S_HALT;
                  default:           w_next = S_ERR;
               endcase
            end
         end
         S_EXEC:   w_next = (w_opc == OP_LOAD || w_opc == OP_STORE) ? S_MEM : S_WB;
         S_MEM:    if (bus.mem_ready) w_next = (w_opc == OP_STORE) ? S_FETCH : S_WB;
                   else if (w_expired) w_next = S_ERR;
         S_WB, S_BR:     w_next = S_FETCH;
         S_HALT, S_ERR:  w_next = r_state;
         default:        w_next = S_ERR;
      endcase
   end

   always_comb begin
      w_ctl = '0;
      case (w_next)
         S_FETCH: w_ctl.mem_rd = 1'b1;
         S_IRL: begin
            w_ctl.ir_write = 1'b1;
            w_ctl.pc_write = 1'b1;
         end
         S_EXEC: begin
            w_ctl.alu_src_a = 1'b1;
            if (is_alu_op(w_opc)) w_ctl.alu_op = w_opc[2:0];
            else begin
               w_ctl.alu_src_b = 1'b1;
               w_ctl.alu_op    = ALU_ADD;
            end
         end
         S_MEM: begin
            w_ctl.mem_addr_sel = 1'b1;
            if (w_opc == OP_STORE) w_ctl.mem_wr = 1'b1;
            else                   w_ctl.mem_rd = 1'b1;
         end
         S_WB: begin
            w_ctl.reg_write = 1'b1;
            w_ctl.rdw_sel   = (w_opc == OP_LOAD)  ? RDW_MEM :
                              (w_opc == OP_LOADI) ? RDW_IMM : RDW_ALU;
         end
         S_BR: if (|bus.cmpRst) begin
            w_ctl.pc_write  = 1'b1;
            w_ctl.pc_source = 1'b1;
            w_ctl.alu_src_b = 1'b1;
         end
         S_HALT:  w_ctl.halted = 1'b1;
         S_ERR:   w_ctl.error  = 1'b1;
         default: w_ctl = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH;
         r_opc   <= '0;
         r_ctl   <= CTL_RESET;
      end else begin
         r_state <= w_next;
         r_opc   <= w_opc;
         r_ctl   <= w_ctl;
      end
   end

   assign bus.IRWrite        = r_ctl.ir_write;
   assign bus.PCWriteEnable  = r_ctl.pc_write;
   assign bus.PCSource       = r_ctl.pc_source;
   assign bus.memEnableRead  = r_ctl.mem_rd;
   assign bus.memEnableWrite = r_ctl.mem_wr;
   assign bus.memAddrSel     = r_ctl.mem_addr_sel;
   assign bus.ALUSrcA        = r_ctl.alu_src_a;
   assign bus.ALUSrcB        = r_ctl.alu_src_b;
   assign bus.ALUOp          = r_ctl.alu_op;
   assign bus.immShift       = r_ctl.imm_shift;
   assign bus.writeEnable    = r_ctl.reg_write;
   assign bus.regDataWrite   = r_ctl.rdw_sel;
   assign bus.halted         = r_ctl.halted;
   assign bus.error          = r_ctl.error;
   assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_mc_control_sequencer.sv
// Bench for mc_control_sequencer: directed scenarios plus random instruction
// streams, checked cycle by cycle against a phase-list reference model.
module tb_mc_control_sequencer;
   import cpu_ctrl_pkg::*;

   localparam int W        = 19;
   localparam int WAIT_MAX = 15;

   localparam int B_IRW = 18, B_PCW = 17, B_PCS = 16, B_MRD = 15, B_MWR = 14;
   localparam int B_MAS = 13, B_SA = 12, B_SB = 11, B_WE = 5, B_HLT = 1, B_ERR = 0;

   localparam logic [W-1:0] C_FETCH  = W'(1) << B_MRD;
   localparam logic [W-1:0] C_IRL    = (W'(1) << B_IRW) | (W'(1) << B_PCW);
   localparam logic [W-1:0] C_ADDR   = (W'(1) << B_SA) | (W'(1) << B_SB);
   localparam logic [W-1:0] C_LD_MEM = (W'(1) << B_MRD) | (W'(1) << B_MAS);
   localparam logic [W-1:0] C_ST_MEM = (W'(1) << B_MWR) | (W'(1) << B_MAS);
   localparam logic [W-1:0] C_BR_TK  = (W'(1) << B_PCW) | (W'(1) << B_PCS) | (W'(1) << B_SB);
   localparam logic [W-1:0] C_HALT   = W'(1) << B_HLT;
   localparam logic [W-1:0] C_ERR    = W'(1) << B_ERR;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   mc_control_sequencer_if #(.OP_W(4), .CMP_W(2)) bus();

   mc_control_sequencer #(.OP_W(4), .CMP_W(2), .MEM_WAIT_MAX(WAIT_MAX), .TO_W(4)) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- reference model ----------------
   // Each instruction is a list of phases; a wait phase stays at the head until
   // mem_ready, and WAIT_MAX consecutive misses replace the list with ERR.
   logic [W-1:0] exp_q[$];
   bit           wait_q[$];
   int           wait_cnt = 0;

   function automatic logic [W-1:0] get_obs();
      return {bus.IRWrite, bus.PCWriteEnable, bus.PCSource, bus.memEnableRead,
              bus.memEnableWrite, bus.memAddrSel, bus.ALUSrcA, bus.ALUSrcB,
              bus.ALUOp, bus.immShift, bus.writeEnable, bus.regDataWrite,
              bus.halted, bus.error};
   endfunction

   function automatic logic [W-1:0] wb_word(input logic [2:0] k);
      return (W'(1) << B_WE) | (W'(k) << 2);
   endfunction

   task automatic push(input logic [W-1:0] w, input bit wt);
      exp_q.push_back(w);
      wait_q.push_back(wt);
   endtask

   task automatic model_clear();
      exp_q.delete();
      wait_q.delete();
      wait_cnt = 0;
   endtask

   task automatic model_load(input logic [3:0] opc, input logic [1:0] cmp);
      push(C_FETCH, 1'b1);
      push(C_IRL, 1'b0);
      push({W{1'b0}}, 1'b0);
      if (opc < 4'h8) begin
         push((W'(1) << B_SA) | (W'(opc[2:0]) << 8), 1'b0);
         push(wb_word(3'd0), 1'b0);
      end else begin
         case (opc)
            4'h8: begin push(C_ADDR, 1'b0); push(C_LD_MEM, 1'b1); push(wb_word(3'd1), 1'b0); end
            4'h9: begin push(C_ADDR, 1'b0); push(C_ST_MEM, 1'b1); end
            4'hA: push((cmp != 2'b00) ? C_BR_TK : {W{1'b0}}, 1'b0);
            4'hB: push(wb_word(3'd2), 1'b0);
            4'hF: push(C_HALT, 1'b0);
            default: push(C_ERR, 1'b0);
         endcase
      end
   endtask

   task automatic model_step(input logic rdy, output logic [W-1:0] e);
      e = exp_q[0];
      if (e[B_HLT] || e[B_ERR]) return;
      if (wait_q[0] && !rdy) begin
         wait_cnt++;
         if (WAIT_MAX != 0 && wait_cnt == WAIT_MAX) begin
            model_clear();
            push(C_ERR, 1'b0);
         end
      end else begin
         void'(exp_q.pop_front());
         void'(wait_q.pop_front());
         wait_cnt = 0;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic cycle(input logic rdy, output logic [W-1:0] o);
      bus.mem_ready = rdy;
      o = get_obs();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      reset = 1'b1;
      model_clear();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0;
      bus.op = 4'hA; bus.cmpRst = 2'b11; bus.mem_ready = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      total++;
      if (get_obs() !== C_FETCH) begin
         bad++; $display("FAIL reset_word got=%h exp=%h", get_obs(), C_FETCH);
      end
      total++;
      if ({bus.halted, bus.error} !== 2'b00) begin
         bad++; $display("FAIL reset_flags got=%b exp=00", {bus.halted, bus.error});
      end
      reset = 1'b1;
      model_clear();
   endtask

   task automatic test_alu();
      logic [W-1:0] o, e;
      int n = 0, we_cnt = 0, irw_cyc = 0;
      bus.op = 4'h3; bus.cmpRst = 2'b00;
      model_load(4'h3, 2'b00);
      while (exp_q.size() != 0 && n < 40) begin
         n++;
         cycle(1'b1, o);
         model_step(1'b1, e);
         if (o[B_WE]) we_cnt++;
         if (o[B_IRW]) irw_cyc = n;
         total++;
         if (o !== e) begin bad++; $display("FAIL alu cyc=%0d got=%h exp=%h st=%0d", n, o, e, bus.dbg_state); end
      end
      total++;
      if (n !== 5) begin bad++; $display("FAIL alu_latency got=%0d exp=5", n); end
      total++;
      if (we_cnt !== 1) begin bad++; $display("FAIL alu_we_count got=%0d exp=1", we_cnt); end
      total++;
      if (irw_cyc !== 2) begin bad++; $display("FAIL alu_irwrite_cycle got=%0d exp=2", irw_cyc); end
      total++;
      if (get_obs() !== C_FETCH) begin bad++; $display("FAIL alu_then_fetch got=%h exp=%h", get_obs(), C_FETCH); end
   endtask

   task automatic test_load_wait();
      logic [W-1:0] o, e;
      logic rdy;
      int n = 0, stalls = 0, mas_cnt = 0;
      bus.op = 4'h8;
      model_load(4'h8, 2'b00);
      while (exp_q.size() != 0 && n < 40) begin
         n++;
         rdy = !(exp_q[0] == C_LD_MEM && stalls < 4);
         if (!rdy) stalls++;
         cycle(rdy, o);
         model_step(rdy, e);
         if (o[B_MRD] && o[B_MAS]) mas_cnt++;
         total++;
         if (o !== e) begin bad++; $display("FAIL load cyc=%0d got=%h exp=%h st=%0d", n, o, e, bus.dbg_state); end
      end
      total++;
      if (mas_cnt !== 5) begin bad++; $display("FAIL load_mem_hold got=%0d exp=5", mas_cnt); end
      total++;
      if (n !== 10) begin bad++; $display("FAIL load_latency got=%0d exp=10", n); end
   endtask

   task automatic test_branch();
      logic [W-1:0] o, e;
      for (int k = 0; k < 2; k++) begin
         int n = 0, pcs_cnt = 0;
         logic [1:0] cmp;
         cmp = (k == 0) ? 2'b01 : 2'b00;
         bus.op = 4'hA; bus.cmpRst = cmp;
         model_load(4'hA, cmp);
         while (exp_q.size() != 0 && n < 40) begin
            n++;
            cycle(1'b1, o);
            model_step(1'b1, e);
            if (o[B_PCS] && o[B_PCW]) pcs_cnt++;
            total++;
            if (o !== e) begin bad++; $display("FAIL branch%0d cyc=%0d got=%h exp=%h", k, n, o, e); end
         end
         total++;
         if (pcs_cnt !== ((k == 0) ? 1 : 0)) begin bad++; $display("FAIL branch%0d_pcwrite got=%0d exp=%0d", k, pcs_cnt, (k == 0) ? 1 : 0); end
         total++;
         if (n !== 4) begin bad++; $display("FAIL branch%0d_latency got=%0d exp=4", k, n); end
      end
   endtask

   task automatic test_timeout();
      logic [W-1:0] o, e;
      logic rdy;
      int n;
      // Ready arriving on the last tolerated cycle still completes the fetch.
      bus.op = 4'h1; bus.cmpRst = 2'b00;
      model_load(4'h1, 2'b00);
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         n++;
         rdy = (n >= WAIT_MAX);
         cycle(rdy, o);
         model_step(rdy, e);
         total++;
         if (o !== e) begin bad++; $display("FAIL timeout_edge cyc=%0d got=%h exp=%h st=%0d", n, o, e, bus.dbg_state); end
      end
      total++;
      if (get_obs() !== C_FETCH) begin bad++; $display("FAIL timeout_edge_done got=%h exp=%h", get_obs(), C_FETCH); end

      model_load(4'h1, 2'b00);
      for (n = 1; n <= WAIT_MAX + 3; n++) begin
         cycle(1'b0, o);
         model_step(1'b0, e);
         total++;
         if (o !== e) begin bad++; $display("FAIL timeout cyc=%0d got=%h exp=%h st=%0d", n, o, e, bus.dbg_state); end
      end
      total++;
      if (get_obs() !== C_ERR) begin bad++; $display("FAIL timeout_err got=%h exp=%h", get_obs(), C_ERR); end
      do_reset();
   endtask

   task automatic test_terminal(input logic [3:0] opc, input logic [W-1:0] term);
      logic [W-1:0] o, e;
      logic rdy;
      bus.op = opc; bus.cmpRst = 2'b00;
      model_load(opc, 2'b00);
      for (int n = 1; n <= 12; n++) begin
         rdy = 1'b1;
         if (n >= 4) begin
            rdy = 1'($urandom_range(0, 1));
            bus.op = 4'($urandom_range(0, 15));
            bus.cmpRst = 2'($urandom_range(0, 3));
         end
         cycle(rdy, o);
         model_step(rdy, e);
         total++;
         if (o !== e) begin bad++; $display("FAIL terminal_%h cyc=%0d got=%h exp=%h", opc, n, o, e); end
      end
      total++;
      if (get_obs() !== term) begin bad++; $display("FAIL terminal_%h_sticky got=%h exp=%h", opc, get_obs(), term); end
      do_reset();
      total++;
      if (get_obs() !== C_FETCH) begin bad++; $display("FAIL terminal_%h_cleared got=%h exp=%h", opc, get_obs(), C_FETCH); end
   endtask

   task automatic test_reset_mid_store();
      logic [W-1:0] o, e;
      int n = 0, mwr_cnt = 0;
      bus.op = 4'h9; bus.cmpRst = 2'b00;
      model_load(4'h9, 2'b00);
      while (exp_q[0] != C_ST_MEM && n < 20) begin
         n++;
         cycle(1'b1, o);
         model_step(1'b1, e);
         total++;
         if (o !== e) begin bad++; $display("FAIL store cyc=%0d got=%h exp=%h", n, o, e); end
      end
      cycle(1'b0, o);
      model_step(1'b0, e);
      total++;
      if (o !== C_ST_MEM) begin bad++; $display("FAIL store_mem got=%h exp=%h", o, C_ST_MEM); end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (bus.memEnableWrite !== 1'b0) begin bad++; $display("FAIL store_abort_wr got=%b exp=0", bus.memEnableWrite); end
      total++;
      if (get_obs() !== C_FETCH) begin bad++; $display("FAIL store_abort_word got=%h exp=%h", get_obs(), C_FETCH); end
      @(posedge CLK);
      #1;
      reset = 1'b1;
      model_clear();
      bus.op = 4'h5;
      model_load(4'h5, 2'b00);
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         n++;
         cycle(1'b1, o);
         model_step(1'b1, e);
         if (o[B_MWR]) mwr_cnt++;
         total++;
         if (o !== e) begin bad++; $display("FAIL after_abort cyc=%0d got=%h exp=%h", n, o, e); end
      end
      total++;
      if (mwr_cnt !== 0) begin bad++; $display("FAIL after_abort_write got=%0d exp=0", mwr_cnt); end
   endtask

   task automatic test_random();
      logic [W-1:0] o, e;
      logic [3:0] opc;
      logic [1:0] cmp;
      logic rdy;
      for (int i = 0; i < 40; i++) begin
         int r, n, term_cnt;
         bit long_stall;
         r = $urandom_range(0, 19);
         if (r < 12)       opc = 4'(r);
         else if (r < 16)  opc = 4'($urandom_range(0, 7));
         else if (r == 16) opc = 4'hF;
         else if (r == 17) opc = 4'(12 + $urandom_range(0, 2));
         else              opc = 4'(8 + $urandom_range(0, 1));
         cmp = 2'($urandom_range(0, 3));
         long_stall = ($urandom_range(0, 9) == 0);
         bus.op = opc; bus.cmpRst = cmp;
         model_load(opc, cmp);
         n = 0; term_cnt = 0;
         while (exp_q.size() != 0 && n < 200 && term_cnt < 3) begin
            n++;
            rdy = long_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (exp_q[0][B_HLT] || exp_q[0][B_ERR]) term_cnt++;
            cycle(rdy, o);
            model_step(rdy, e);
            total++;
            if (o !== e) begin bad++; $display("FAIL rand%0d op=%h cyc=%0d got=%h exp=%h st=%0d", i, opc, n, o, e, bus.dbg_state); end
         end
         if (n >= 200) begin
            total++; bad++;
            $display("FAIL rand%0d_bound op=%h got=%0d cycles exp<200", i, opc, n);
         end
         if (term_cnt != 0 || n >= 200) do_reset();
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      reset = 1'b0;
      bus.op = 4'h0; bus.cmpRst = 2'b00; bus.mem_ready = 1'b0;
      test_reset();
      test_alu();
      test_load_wait();
      test_branch();
      test_timeout();
      test_terminal(4'hD, C_ERR);
      test_terminal(4'hF, C_HALT);
      test_reset_mid_store();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
